booth_mul_param: RTL and testbench
==================================

Name: booth_mul_param

Overview:
- Parametrised, handshaked sequential Booth multiplier; next generation of the team's 8-bit datapath/controller multiplier.
- Both operands are captured in one cycle, on separate ports.
- Supports signed and unsigned operands at run time, and any even operand width.
- Sits between an operand-producing master (start/done handshake) and downstream logic that consumes the registered 2*WIDTH product.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and >= 4.
- CNT_W, $clog2(WIDTH+2): iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous, active-low reset; clears all state and outputs.
- start  in  1  request; sampled only when busy=0.
- multiplicand  in  WIDTH  operand M; captured at the accepted start.
- multiplier  in  WIDTH  operand Q; captured at the accepted start.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured at the accepted start.
- busy  out  1  high while iterating.
- done  out  1  high from completion until the next accepted start.
- product  out  2*WIDTH  registered result; stable while done=1.

Behaviour:
- Reset (clr_n=0, async): state=IDLE, busy=0, done=0, product=0, internal A/Q/Q_-1/M/count=0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on start=1 at a rising edge; done deasserts on that edge.
  - RUN -> DONE when count reaches 0.
  - DONE holds until start or reset.
- Accept edge t0:
  - M <= ext(multiplicand); Q <= ext(multiplier); A <= 0; Q_-1 <= 0; count <= ITER; busy <= 1.
  - ext() = sign-extension if is_signed, else zero-extension, to WIDTH+1 bits (radix-2).
- Radix-2 RUN iteration (one clock each):
  - {Q0,Q_-1}=10: A<=A-M. 01: A<=A+M. 00/11: no add.
  - Then arithmetic right shift of {A,Q,Q_-1} by 1; add and shift happen in the same cycle.
  - count decrements by 1.
- Radix-2 ITER = WIDTH+1.
- Arithmetic: A is WIDTH+1 bits (WIDTH+2 in radix-4); overflow is discarded, two's-complement wrap.
- Result: product <= low 2*WIDTH bits of {A,Q} (the arithmetic result), registered on the edge the FSM enters DONE.
- Timing:
  - done=1 and busy=0 become visible after edge t0+ITER (latency ITER clocks from acceptance).
  - busy=1 after edges t0 .. t0+ITER-1.
- start while busy=1: ignored; operands are not re-captured; the operation is unaffected.
- start=1 in DONE: accepted; the previous product holds until the new result loads.
- Back-to-back operation: start held high continuously gives one result every ITER+1 clocks.
- Operand changes while busy: no effect.
- Reset mid-RUN: immediate abort to IDLE; the partial result is discarded; product=0.
- Corner cases:
  - Most-negative signed operands (e.g. -128*-128 at WIDTH=8) give the exact result.
  - Unsigned all-ones operands give the exact result.

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined: radix-4 (modified Booth) recoding.
  - Multiplier extended to WIDTH+2 bits; examines {Q1,Q0,Q_-1} per iteration.
  - Digit select: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Then arithmetic right shift by 2.
  - ITER = WIDTH/2+1, giving latency 5 at WIDTH=8.
  - The A datapath is WIDTH+2 bits to hold ±2M.
- Undefined: radix-2 only, ITER = WIDTH+1, latency 9 at WIDTH=8.
- Port list and handshake are identical in both builds.

Test Plan (WIDTH=8; ITER=9, or 5 with BOOTH_RADIX4_EN):
- Signed pair: is_signed=1, M=7, Q=-3 (0xFD), start 1 cycle -> done after ITER clocks, product=0xFFEB; busy high for exactly ITER cycles.
- Signed extremes: is_signed=1, M=0x80, Q=0x80 -> product=0x4000. Then M=0x80, Q=0x7F -> product=0xC080.
- Unsigned extremes: is_signed=0, M=0xFF, Q=0xFF -> product=0xFE01. Then is_signed=0, M=0x00, Q=0xA5 -> product=0x0000.
- Busy protection: start pulsed again 3 cycles after acceptance, with operands changed to 0x11/0x22 -> ignored; the original result (M=12, Q=10 signed -> 0x0078) is delivered on time.
- Back-to-back: start held high with (5,6) then (-2,9) -> products 0x001E then 0xFFEE; results spaced ITER+1 clocks apart; done low for exactly the re-accept cycles.
- Reset mid-op: clr_n low 4 cycles after start (async, between edges) -> busy/done/product go to 0 immediately. A new start after release yields correct 3*3=0x0009.

Source files
------------

// File: rtl/booth_mul_param_if.sv
// Operand/result bundle for booth_mul_param: start/done handshake, two operands, signedness, product.
interface booth_mul_param_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 is_signed;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier, is_signed,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier, is_signed,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul_param.sv
// Sequential Booth multiplier, signed/unsigned at run time; radix-4 recoding when BOOTH_RADIX4_EN is defined.
// Latency ITER clocks from accepted start (WIDTH+1 radix-2, WIDTH/2+1 radix-4); product registered on DONE entry.
// Backpressure: start is ignored while busy; done holds the product until the next accepted start.
module booth_mul_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH+2)
) (
    input  logic              clk,
    input  logic              clr_n,
    booth_mul_param_if.slave  bus
);

`ifdef BOOTH_RADIX4_EN
    localparam int AW   = WIDTH + 2;
    localparam int QW   = WIDTH + 2;
    localparam int ITER = WIDTH/2 + 1;
`else
    localparam int AW   = WIDTH + 1;
    localparam int QW   = WIDTH + 1;
    localparam int ITER = WIDTH + 1;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [AW-1:0]        r_a;
    logic [AW-1:0]        r_m;
    logic [QW-1:0]        r_q;
    logic                 r_qm1;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [AW-1:0]        w_m_ext;
    logic [QW-1:0]        w_q_ext;
    logic [AW-1:0]        w_addend;
    logic [AW-1:0]        w_sum;
    logic [AW-1:0]        w_a_nx;
    logic [QW-1:0]        w_q_nx;
    logic                 w_qm1_nx;

    always_comb begin
        w_m_ext = bus.is_signed ? {{(AW-WIDTH){bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                : {{(AW-WIDTH){1'b0}}, bus.multiplicand};
        w_q_ext = bus.is_signed ? {{(QW-WIDTH){bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                : {{(QW-WIDTH){1'b0}}, bus.multiplier};
    end

`ifdef BOOTH_RADIX4_EN
    // Modified Booth digit from {Q1,Q0,Q_-1}; A is wide enough that +-2M never wraps.
    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = r_m;
            3'b011:         w_addend = {r_m[AW-2:0], 1'b0};
            3'b100:         w_addend = '0 - {r_m[AW-2:0], 1'b0};
            3'b101, 3'b110: w_addend = '0 - r_m;
            default:        w_addend = '0;
        endcase
        w_sum    = r_a + w_addend;
        w_a_nx   = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
        w_q_nx   = {w_sum[1:0], r_q[QW-1:2]};
        w_qm1_nx = r_q[1];
    end
`else
    always_comb begin
        w_addend = '0;
        case ({r_q[0], r_qm1})
            2'b10:   w_addend = '0 - r_m;
            2'b01:   w_addend = r_m;
            default: w_addend = '0;
        endcase
        w_sum    = r_a + w_addend;
        w_a_nx   = {w_sum[AW-1], w_sum[AW-1:1]};
        w_q_nx   = {w_sum[0], r_q[QW-1:1]};
        w_qm1_nx = r_q[0];
    end
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_m     <= w_m_ext;
                        r_q     <= w_q_ext;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= CNT_W'(ITER);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_nx;
                    r_q   <= w_q_nx;
                    r_qm1 <= w_qm1_nx;
                    r_cnt <= r_cnt - 1'b1;
                    // Last iteration: the shifted {A,Q} already holds the full product.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= {w_a_nx[2*WIDTH-QW-1:0], w_q_nx};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule

// File: tb/tb_booth_mul_param.sv
// Randomised and directed bench for booth_mul_param (WIDTH=8), checked against a plain-arithmetic model.
module tb_booth_mul_param;

    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = W/2 + 1;
`else
    localparam int ITER = W + 1;
`endif

    logic clk;
    logic clr_n;
    int   n_checks;
    int   n_errors;

    booth_mul_param_if #(.WIDTH(W)) bus ();

    booth_mul_param #(.WIDTH(W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q, input logic s);
        longint p;
        if (s) p = longint'($signed(m)) * longint'($signed(q));
        else   p = longint'(m) * longint'(q);
        return p[15:0];
    endfunction

    // One operation: latency measured as negedges with busy high after acceptance.
    task automatic do_op(input logic [7:0] m, input logic [7:0] q, input logic s,
                         input bit glitch, input string tag);
        int cnt;
        logic [15:0] exp;
        exp = ref_mul(m, q, s);
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = m; bus.multiplier = q; bus.is_signed = s;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (glitch && cnt == 3) begin
                bus.start = 1'b1; bus.multiplicand = 8'h11; bus.multiplier = 8'h22; bus.is_signed = ~s;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_lat"},  cnt, ITER);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_prod"}, {16'd0, bus.product}, {16'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [7:0] rm, rq;
        logic rs;
        n_checks = 0;
        n_errors = 0;
        clr_n = 1'b0;
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0; bus.is_signed = 1'b0;
        #12;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_prod", {16'd0, bus.product}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        do_op(8'd7,   8'hFD, 1'b1, 1'b0, "s_7xm3");
        chk("s_7xm3_const", {16'd0, bus.product}, 32'h0000FFEB);
        do_op(8'h80,  8'h80, 1'b1, 1'b0, "s_m128sq");
        chk("s_m128sq_const", {16'd0, bus.product}, 32'h00004000);
        do_op(8'h80,  8'h7F, 1'b1, 1'b0, "s_m128x127");
        chk("s_m128x127_const", {16'd0, bus.product}, 32'h0000C080);
        do_op(8'hFF,  8'hFF, 1'b0, 1'b0, "u_ffxff");
        chk("u_ffxff_const", {16'd0, bus.product}, 32'h0000FE01);
        do_op(8'h00,  8'hA5, 1'b0, 1'b0, "u_0xa5");
        do_op(8'd12,  8'd10, 1'b1, 1'b1, "busy_prot");
        chk("busy_prot_const", {16'd0, bus.product}, 32'h00000078);

        for (int i = 0; i < 30; i++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            rs = 1'($urandom);
            do_op(rm, rq, rs, 1'($urandom_range(0, 3) == 0), "rand");
        end

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 8'd5; bus.multiplier = 8'd6; bus.is_signed = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (bus.done !== 1'b1 && cnt < 100);
        chk("b2b_first_lat", cnt, ITER + 1);
        chk("b2b_first_prod", {16'd0, bus.product}, 32'h0000001E);
        bus.multiplicand = 8'hFE; bus.multiplier = 8'd9;
        @(negedge clk);
        chk("b2b_reacc_done", {31'd0, bus.done}, 32'd0);
        chk("b2b_reacc_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_hold_prod",  {16'd0, bus.product}, 32'h0000001E);
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("b2b_spacing", cnt, ITER + 1);
        chk("b2b_second_prod", {16'd0, bus.product}, {16'd0, ref_mul(8'hFE, 8'd9, 1'b1)});
        chk("b2b_second_const", {16'd0, bus.product}, 32'h0000FFEE);
        bus.start = 1'b0;

        // Asynchronous reset in the middle of an operation.
        do_op(8'd100, 8'hCE, 1'b1, 1'b0, "pre_rst");
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 8'd33; bus.multiplier = 8'd44; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_prod", {16'd0, bus.product}, 32'd0);
        @(negedge clk);
        chk("midrst_hold_busy", {31'd0, bus.busy}, 32'd0);
        clr_n = 1'b1;
        do_op(8'd3, 8'd3, 1'b1, 1'b0, "post_rst");
        chk("post_rst_const", {16'd0, bus.product}, 32'h00000009);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
